// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit. Sits between the register bank read ports
// (base/store data) and its write port (rd/we/wdata). It runs one data-bus
// transaction per instruction and returns a one-cycle write-back strobe.
module rv32i_lsu #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          start_i,
  input  logic          is_store_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   base_i,
  input  logic [11:0]   offset_i,
  input  logic [31:0]   sdata_i,
  input  logic [3:0]    rd_i,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [3:0]    bus_be_o,
  output logic [31:0]   bus_wdata_o,
  input  logic [31:0]   bus_rdata_i,
  input  logic          bus_ack_i,
  output logic [3:0]    rd_o,
  output logic          we_o,
  output logic [31:0]   wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Captured instruction context needed after the start edge.
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] ea_lo;
    logic [3:0] rd;
  } op_t;

  state_t      state_q;
  op_t         op_q;

  logic [31:0] ea;
  logic        f3_bad;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ld_data;

  // Effective address, legality and store lane formatting for the incoming op.
  always_comb begin
    ea     = base_i + {{20{offset_i[11]}}, offset_i};
    f3_bad = 1'b0;
    misal  = 1'b0;
    be_n   = 4'b1111;
    wd_n   = sdata_i;
    if (is_store_i)
      f3_bad = !(funct3_i inside {3'b000, 3'b001, 3'b010});
    else
      f3_bad = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // funct3[1:0] encodes the access size for every legal code
    case (funct3_i[1:0])
      2'b00: begin
        be_n = 4'b0001 << ea[1:0];
        wd_n = {4{sdata_i[7:0]}};
      end
      2'b01: begin
        misal = ea[0];
        be_n  = ea[1] ? 4'b1100 : 4'b0011;
        wd_n  = {2{sdata_i[15:0]}};
      end
      2'b10: misal = (ea[1:0] != 2'b00);
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of the returned bus word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = bus_rdata_i[8*op_q.ea_lo +: 8];
    h = op_q.ea_lo[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (op_q.funct3)
      3'b000:  ld_data = {{24{b[7]}}, b};
      3'b100:  ld_data = {24'h0, b};
      3'b001:  ld_data = {{16{h[15]}}, h};
      3'b101:  ld_data = {16'h0, h};
      default: ld_data = bus_rdata_i;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // Control FSM with registered bus and write-back outputs.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      op_q        <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      rd_o        <= '0;
      we_o        <= 1'b0;
      wdata_o     <= '0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q <= '{is_store: is_store_i, funct3: funct3_i, ea_lo: ea[1:0], rd: rd_i};
            if (f3_bad || misal) begin
              // faults skip the bus entirely and report next cycle
              state_q <= RESP;
              done_o  <= 1'b1;
              fault_o <= 1'b1;
              we_o    <= 1'b0;
              rd_o    <= rd_i;
              wdata_o <= '0;
            end else begin
              state_q     <= REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store_i;
              bus_addr_o  <= {ea[AW-1:2], 2'b00};
              bus_be_o    <= be_n;
              bus_wdata_o <= wd_n;
            end
          end
        end
        REQ: begin
          // wait indefinitely for the bus; start_i is ignored here
          if (bus_ack_i) begin
            state_q     <= RESP;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            done_o      <= 1'b1;
            we_o        <= !op_q.is_store;
            rd_o        <= op_q.rd;
            wdata_o     <= op_q.is_store ? 32'h0 : ld_data;
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
          we_o    <= 1'b0;
          fault_o <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: stimulus pushes expected bus requests and
// write-back responses; an independent negedge monitor pops and compares.
module tb_rv32i_lsu;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] base_i = '0;
  logic [11:0] offset_i = '0;
  logic [31:0] sdata_i = '0;
  logic [3:0]  rd_i = '0;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
  logic [3:0]  rd_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        busy_o, done_o, fault_o;

  rv32i_lsu #(.AW(32)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(start_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .base_i(base_i), .offset_i(offset_i), .sdata_i(sdata_i),
    .rd_i(rd_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .rd_o(rd_o), .we_o(we_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic        fault;
    int          lat;
    int          start_cyc;
  } resp_t;

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;   // -1: request is cut short by reset
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares bus requests and write-back strobes against the queues.
  initial begin
    int run;
    bus_t  b;
    resp_t r;
    run = 0;
    forever begin
      @(negedge clk_i);
      if (bus_req_o) begin
        if (bq.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          b = bq[0];
          chk({b.nm, ".bus_addr"}, bus_addr_o, b.addr);
          chk({b.nm, ".bus_be"}, {28'h0, bus_be_o}, {28'h0, b.be});
          chk({b.nm, ".bus_we"}, {31'h0, bus_we_o}, {31'h0, b.we});
          if (b.we) chk({b.nm, ".bus_wdata"}, bus_wdata_o, b.wdata);
        end
        run++;
      end else if (run > 0) begin
        if (bq.size() != 0) begin
          b = bq.pop_front();
          if (b.cycles >= 0) chk({b.nm, ".req_cycles"}, run, b.cycles);
        end
        run = 0;
      end
      if (done_o) begin
        if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk({r.nm, ".rd"}, {28'h0, rd_o}, {28'h0, r.rd});
          chk({r.nm, ".we"}, {31'h0, we_o}, {31'h0, r.we});
          chk({r.nm, ".fault"}, {31'h0, fault_o}, {31'h0, r.fault});
          chk({r.nm, ".latency"}, cyc - r.start_cyc, r.lat);
          if (r.we) chk({r.nm, ".wdata"}, wdata_o, r.wdata);
        end
      end else begin
        chk("idle_strobes", {30'h0, we_o, fault_o}, 32'h0);
      end
    end
  end

  // Issue one op (called #1 after a rising edge) and play the bus side.
  task automatic op(input string nm, input logic st, input logic [2:0] f3,
                    input logic [31:0] base, input logic [11:0] off,
                    input logic [31:0] sd, input logic [3:0] rd,
                    input int waits, input logic [31:0] rdata, input logic flt,
                    input logic [31:0] eaddr, input logic [3:0] ebe,
                    input logic [31:0] ebwd, input logic [31:0] ewd, input bit pulse);
    is_store_i = st; funct3_i = f3; base_i = base; offset_i = off;
    sdata_i = sd; rd_i = rd; start_i = 1'b1;
    rq.push_back('{nm, rd, !st && !flt, ewd, flt, flt ? 0 : waits + 1, cyc + 1});
    if (!flt) bq.push_back('{nm, st, eaddr, ebe, ebwd, waits + 1});
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (!flt) begin
      for (int i = 0; i < waits; i++) begin
        if (pulse && i == 0) begin
          // a different op offered mid-request must be ignored
          start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010;
          base_i = 32'h500; offset_i = '0; sdata_i = 32'h55AA55AA;
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
      end
      bus_ack_i = 1'b1; bus_rdata_i = rdata;
      @(posedge clk_i); #1;
      bus_ack_i = 1'b0; bus_rdata_i = '0;
    end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit seen;
    #1 rst_in = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.ctrl", {26'h0, bus_req_o, bus_we_o, we_o, busy_o, done_o, fault_o}, 32'h0);
    chk("rst.bus", {bus_be_o, 28'h0} | bus_addr_o | bus_wdata_o, 32'h0);
    chk("rst.wb", {rd_o, 28'h0} | wdata_o, 32'h0);
    rst_in = 1'b1;
    @(posedge clk_i); #1;

    //  name     st  f3      base          off     sdata         rd  w  rdata         flt  addr          be       bus wdata     wb data
    op("lw",     0, 3'b010, 32'h100,      12'hFFC, 32'h0,        5, 3, 32'hDEADBEEF, 0, 32'h0FC,      4'b1111, 32'h0,        32'hDEADBEEF, 0);
    op("lb",     0, 3'b000, 32'h200,      12'h003, 32'h0,        6, 1, 32'h80112233, 0, 32'h200,      4'b1000, 32'h0,        32'hFFFFFF80, 0);
    op("lbu",    0, 3'b100, 32'h200,      12'h003, 32'h0,        7, 0, 32'h80112233, 0, 32'h200,      4'b1000, 32'h0,        32'h00000080, 0);
    op("lhu",    0, 3'b101, 32'h200,      12'h002, 32'h0,        8, 2, 32'h80112233, 0, 32'h200,      4'b1100, 32'h0,        32'h00008011, 0);
    op("lh",     0, 3'b001, 32'h300,      12'h000, 32'h0,        9, 0, 32'h1234F00F, 0, 32'h300,      4'b0011, 32'h0,        32'hFFFFF00F, 0);
    op("sb",     1, 3'b000, 32'h400,      12'h001, 32'h000000A5, 1, 1, 32'h0,        0, 32'h400,      4'b0010, 32'hA5A5A5A5, 32'h0,        0);
    op("sh",     1, 3'b001, 32'h400,      12'h002, 32'h00001234, 2, 0, 32'h0,        0, 32'h400,      4'b1100, 32'h12341234, 32'h0,        0);
    op("sw",     1, 3'b010, 32'h800,      12'hFF8, 32'hCAFEF00D, 3, 2, 32'h0,        0, 32'h7F8,      4'b1111, 32'hCAFEF00D, 32'h0,        0);
    op("lw_mis", 0, 3'b010, 32'h100,      12'h002, 32'h0,        4, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    op("f3_011", 0, 3'b011, 32'h100,      12'h000, 32'h0,        5, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    op("sbu_bad",1, 3'b100, 32'h400,      12'h000, 32'h0,        6, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    op("lh_mis", 0, 3'b101, 32'h201,      12'h000, 32'h0,        7, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        0);
    op("wrap",   0, 3'b010, 32'hFFFFFFFC, 12'h008, 32'h0,        9, 2, 32'h0BADF00D, 0, 32'h00000004, 4'b1111, 32'h0,        32'h0BADF00D, 1);

    // Reset in the middle of a request: bus drops at once, a late ack is ignored.
    is_store_i = 1'b0; funct3_i = 3'b010; base_i = 32'h600; offset_i = '0; rd_i = 4'd3;
    start_i = 1'b1;
    bq.push_back('{"rst_mid", 1'b0, 32'h600, 4'b1111, 32'h0, -1});
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #2;
    rst_in = 1'b0;
    #1;
    chk("rst_mid.req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_mid.busy", {31'h0, busy_o}, 32'h0);
    chk("rst_mid.wb", {rd_o, 28'h0} | wdata_o | bus_addr_o, 32'h0);
    @(posedge clk_i); #1;
    rst_in = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11111111;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | done_o | busy_o;
      @(posedge clk_i); #1;
    end
    chk("rst_mid.no_done", {31'h0, seen}, 32'h0);

    op("lw_x0",  0, 3'b010, 32'h700,      12'h010, 32'h0,        0, 0, 32'h13579BDF, 0, 32'h710,      4'b1111, 32'h0,        32'h13579BDF, 0);

    repeat (3) @(posedge clk_i);
    chk("resp_q_drained", rq.size(), 32'd0);
    chk("bus_q_drained", bq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
